matrix_stream_loader: RTL and testbench

Upstream feeder for the 2x2 transpose/multiply stage. Accepts matrix elements serially over a valid/ready stream in row-major order. Assembles them into the packed matrix word the multiply stage consumes as its `a` input, and holds that word under a valid/ready handshake until it is taken. Also provides frame resynchronisation, error flagging and a delivered-matrix counter.

---
 rtl/matrix_stream_loader_pkg.sv | 18 +
 rtl/matrix_stream_loader.sv | 103 ++++++++++
 tb/tb_matrix_stream_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// Shared definitions for the 2x2 matrix loader and multiply stage.
// Packing order lives here so both ends agree on slot placement.
package matrix_stream_loader_pkg;

  localparam int ELEM_W = 4;
  localparam int DIM    = 2;
  localparam int MAT_W  = ELEM_W * DIM * DIM;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int slot_msb(input int k, input int ew);
    return ew * DIM * DIM - 1 - k * ew;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Serial element loader: packs row-major elements into a matrix word
// and holds it under valid/ready, with framing checks and a counter.
module matrix_stream_loader #(
  parameter int ELEM_W        = matrix_stream_loader_pkg::ELEM_W,
  parameter int DIM           = matrix_stream_loader_pkg::DIM,
  parameter int CNT_W         = 8,
  parameter bit REQUIRE_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ELEM_W-1:0]         elem_data,
  input  logic                      elem_first,
  input  logic                      elem_valid,
  output logic                      elem_ready,
  output logic [ELEM_W*DIM*DIM-1:0] mat_data,
  output logic                      mat_valid,
  input  logic                      mat_ready,
  output logic                      sync_err,
  output logic [CNT_W-1:0]          mat_count
);

  import matrix_stream_loader_pkg::*;

  localparam int NS = DIM * DIM;
  localparam int MW = ELEM_W * NS;
  localparam int IW = $clog2(NS);
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NS-1:0][ELEM_W-1:0]    slot_q, slot_d;
  logic [MW-1:0]                mat_q, mat_d;
  logic                         err_q, err_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         take, give;

  assign mat_valid  = (state_q == HOLD);
  assign elem_ready = (state_q == FILL) || mat_ready;
  assign mat_data   = mat_q;
  assign sync_err   = err_q;
  assign mat_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    mat_d   = mat_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    take    = elem_valid && elem_ready;
    give    = mat_valid && mat_ready;

    if (give) begin
      state_d = FILL;
      cnt_d   = cnt_q + 1'b1;
    end

    // idx is already 0 in HOLD, so a handoff-cycle element starts a new matrix
    if (take) begin
      unique case (1'b1)
        (elem_first && idx_q != '0): begin
          slot_d[0] = elem_data;
          idx_d     = IW'(1);
          err_d     = 1'b1;
        end
        (!elem_first && idx_q == '0 && REQUIRE_FIRST): begin
          err_d = 1'b1;
        end
        default: begin
          slot_d[idx_q] = elem_data;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = HOLD;
            for (int k = 0; k < NS; k++) begin
              mat_d[slot_msb(k, ELEM_W) -: ELEM_W] = slot_d[k];
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      slot_q  <= '0;
      mat_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      mat_q   <= mat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: vector table plus
// reset-mid-fill and continuous 256-matrix stream sequences.
module tb_matrix_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  elem_data;
  logic        elem_first;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] mat_data;
  logic        mat_valid;
  logic        mat_ready;
  logic        sync_err;
  logic [7:0]  mat_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(
    .ELEM_W(4), .DIM(2), .CNT_W(8), .REQUIRE_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .elem_data(elem_data), .elem_first(elem_first),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .mat_data(mat_data), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .sync_err(sync_err),
    .mat_count(mat_count)
  );

  typedef struct {
    logic        v, f;
    logic [3:0]  d;
    logic        mr;
    logic        er, mv;
    logic [15:0] md;
    logic        se;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic f, input logic [3:0] d,
                     input logic mr, input logic er, input logic mv,
                     input logic [15:0] md, input logic se,
                     input logic [7:0] cnt);
    vec_t t;
    t = '{v:v, f:f, d:d, mr:mr, er:er, mv:mv, md:md, se:se, cnt:cnt};
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
  endtask

  task automatic drive(input logic v, input logic f,
                       input logic [3:0] d, input logic mr);
    elem_valid = v;
    elem_first = f;
    elem_data  = d;
    mat_ready  = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] smat(input int m);
    return {4'(m), 4'(m + 1), 4'(m + 2), 4'(m + 3)};
  endfunction

  initial begin
    int stalls;
    int errs;

    // v f d mr | er mv md se cnt  (outputs seen before the edge)
    add(1,1,4'h1,1, 1,0,16'h0000,0,8'd0);
    add(1,0,4'h2,1, 1,0,16'h0000,0,8'd0);
    add(1,0,4'h3,1, 1,0,16'h0000,0,8'd0);
    add(1,0,4'h4,1, 1,0,16'h0000,0,8'd0);
    add(0,0,4'h0,1, 1,1,16'h1234,0,8'd0);
    add(0,0,4'h0,0, 1,0,16'h1234,0,8'd1);
    add(1,1,4'h9,0, 1,0,16'h1234,0,8'd1);
    add(1,0,4'h8,0, 1,0,16'h1234,0,8'd1);
    add(1,0,4'h7,0, 1,0,16'h1234,0,8'd1);
    add(1,0,4'h6,0, 1,0,16'h1234,0,8'd1);
    for (int i = 0; i < 5; i++)
      add(1,1,4'h0,0, 0,1,16'h9876,0,8'd1);
    add(0,0,4'h0,1, 1,1,16'h9876,0,8'd1);
    add(1,1,4'hA,0, 1,0,16'h9876,0,8'd2);
    add(1,0,4'hB,0, 1,0,16'h9876,0,8'd2);
    add(1,1,4'hC,0, 1,0,16'h9876,0,8'd2);
    add(1,0,4'hD,0, 1,0,16'h9876,1,8'd2);
    add(1,0,4'hE,0, 1,0,16'h9876,0,8'd2);
    add(1,0,4'hF,0, 1,0,16'h9876,0,8'd2);
    add(0,0,4'h0,1, 1,1,16'hCDEF,0,8'd2);
    add(1,0,4'h5,0, 1,0,16'hCDEF,0,8'd3);
    add(1,1,4'h1,0, 1,0,16'hCDEF,1,8'd3);
    add(1,0,4'h2,0, 1,0,16'hCDEF,0,8'd3);
    add(1,0,4'h3,0, 1,0,16'hCDEF,0,8'd3);
    add(1,0,4'h4,0, 1,0,16'hCDEF,0,8'd3);
    add(0,0,4'h0,1, 1,1,16'h1234,0,8'd3);
    add(0,0,4'h0,0, 1,0,16'h1234,0,8'd4);
    add(1,0,4'h7,0, 1,0,16'h1234,0,8'd4);
    add(1,0,4'h7,0, 1,0,16'h1234,1,8'd4);
    add(0,0,4'h0,0, 1,0,16'h1234,1,8'd4);
    add(0,0,4'h0,0, 1,0,16'h1234,0,8'd4);

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].mr);
      #1;
      chk("elem_ready", i, 32'(elem_ready), 32'(tbl[i].er));
      chk("mat_valid",  i, 32'(mat_valid),  32'(tbl[i].mv));
      chk("mat_data",   i, 32'(mat_data),   32'(tbl[i].md));
      chk("sync_err",   i, 32'(sync_err),   32'(tbl[i].se));
      chk("mat_count",  i, 32'(mat_count),  32'(tbl[i].cnt));
      step();
    end

    // reset after three elements of a partial matrix
    drive(1, 1, 4'h1, 0); step();
    drive(1, 0, 4'h2, 0); step();
    drive(1, 0, 4'h3, 0); step();
    do_reset();
    #1;
    chk("rst_mv",  0, 32'(mat_valid),  32'd0);
    chk("rst_cnt", 0, 32'(mat_count),  32'd0);
    chk("rst_se",  0, 32'(sync_err),   32'd0);
    chk("rst_er",  0, 32'(elem_ready), 32'd1);
    chk("rst_md",  0, 32'(mat_data),   32'd0);
    drive(1, 1, 4'h4, 0); step();
    drive(1, 0, 4'h3, 0); step();
    drive(1, 0, 4'h2, 0); step();
    drive(1, 0, 4'h1, 0); step();
    drive(0, 0, 4'h0, 1);
    #1;
    chk("rst_after_mv", 0, 32'(mat_valid), 32'd1);
    chk("rst_after_md", 0, 32'(mat_data),  32'h4321);
    chk("rst_after_se", 0, 32'(sync_err),  32'd0);
    step();
    chk("rst_after_cnt", 0, 32'(mat_count), 32'd1);

    // continuous stream, next a00 offered on each delivery cycle
    do_reset();
    stalls = 0;
    errs = 0;
    for (int m = 0; m < 256; m++) begin
      for (int e = 0; e < 4; e++) begin
        drive(1, e == 0, 4'(m + e), 1);
        #1;
        if (!elem_ready) stalls++;
        if (sync_err) errs++;
        if (e == 0 && m > 0 && (m % 37 == 1 || m == 255)) begin
          chk("strm_mv",  m, 32'(mat_valid), 32'd1);
          chk("strm_md",  m, 32'(mat_data),  32'(smat(m - 1)));
          chk("strm_cnt", m, 32'(mat_count), 32'(m - 1));
        end
        if (e != 0 && mat_valid) stalls++;
        step();
      end
    end
    drive(0, 0, 4'h0, 1);
    #1;
    chk("strm_last_mv",  0, 32'(mat_valid), 32'd1);
    chk("strm_last_md",  0, 32'(mat_data),  32'(smat(255)));
    chk("strm_last_cnt", 0, 32'(mat_count), 32'd255);
    step();
    chk("strm_wrap_cnt", 0, 32'(mat_count), 32'd0);
    chk("strm_wrap_mv",  0, 32'(mat_valid), 32'd0);
    chk("strm_stalls",   0, 32'(stalls),    32'd0);
    chk("strm_errs",     0, 32'(errs),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
